// File: rtl/spi_regfile.sv
// SPI slave register file: oversampled SPI front end, command/address decode,
// auto-incrementing burst read/write and a flat register bank, all on wb_clk_i.
module spi_regfile #(
  parameter int                DATA_W    = 8,
  parameter int                NREG      = 4,
  parameter bit                CPOL      = 1'b0,
  parameter bit                CPHA      = 1'b0,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int               ADDR_W    = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic                     spi_clk,
  input  logic                     spi_sel,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  output logic                     spi_miso_oeb,
  output logic [NREG*DATA_W-1:0]   reg_data,
  output logic                     wr_stb,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic                     busy
);

  localparam int SH_W = (DATA_W > 8) ? DATA_W : 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  function automatic logic in_range(input logic [6:0] a);
    return ({25'd0, a} < 32'(NREG));
  endfunction

  // Out-of-range addresses read back as zero.
  function automatic logic [DATA_W-1:0] rd_word(input logic [6:0] a,
                                                input logic [NREG-1:0][DATA_W-1:0] r);
    logic [DATA_W-1:0] v;
    if (in_range(a)) begin
      v = r[a[ADDR_W-1:0]];
    end else begin
      v = '0;
    end
    return v;
  endfunction

  logic [2:0]                      sclk_q;
  logic [2:0]                      sel_q;
  logic [1:0]                      mosi_q;
  state_t                          state_q;
  logic [4:0]                      bit_cnt_q;
  logic [SH_W-2:0]                 rx_q;
  logic [6:0]                      addr_q;
  logic                            rw_q;
  logic [DATA_W-1:0]               tx_q;
  logic                            miso_q;
  logic                            busy_q;
  logic                            wr_stb_q;
  logic [ADDR_W-1:0]               wr_addr_q;
  logic [NREG-1:0][DATA_W-1:0]     regs_q;

  logic            clk_rise_s, clk_fall_s, sample_s, shift_s;
  logic            sel_fall_s, sel_rise_s, mosi_s;
  logic [SH_W-1:0] rx_d;
  logic [6:0]      addr_d;

  // 2-FF synchronisers; the third clock/select stage is the edge-detect history.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      sclk_q <= {3{CPOL}};
      sel_q  <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_clk};
      sel_q  <= {sel_q[1:0], spi_sel};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  assign clk_rise_s = sclk_q[1] & ~sclk_q[2];
  assign clk_fall_s = ~sclk_q[1] & sclk_q[2];
  assign sel_fall_s = ~sel_q[1] & sel_q[2];
  assign sel_rise_s = sel_q[1] & ~sel_q[2];
  assign mosi_s     = mosi_q[1];
  // Clock edges seen while select is high are dropped.
  assign sample_s   = ~sel_q[1] & ((CPOL == CPHA) ? clk_rise_s : clk_fall_s);
  assign shift_s    = ~sel_q[1] & ((CPOL == CPHA) ? clk_fall_s : clk_rise_s);
  assign rx_d       = {rx_q, mosi_s};
  assign addr_d     = (addr_q == 7'(NREG - 1)) ? 7'd0 : addr_q + 7'd1;

  // Frame FSM, register bank and registered outputs.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 5'd0;
      rx_q      <= '0;
      addr_q    <= 7'd0;
      rw_q      <= 1'b0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      regs_q    <= {NREG{RESET_VAL}};
    end else begin
      wr_stb_q <= 1'b0;
      if (sel_rise_s) begin
        state_q   <= ST_IDLE;
        busy_q    <= 1'b0;
        miso_q    <= 1'b0;
        bit_cnt_q <= 5'd0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            miso_q <= 1'b0;
            if (sel_fall_s) begin
              state_q   <= ST_CMD;
              busy_q    <= 1'b1;
              bit_cnt_q <= 5'd0;
            end
          end
          ST_CMD: begin
            if (sample_s) begin
              rx_q <= rx_d[SH_W-2:0];
              if (bit_cnt_q == 5'd7) begin
                state_q   <= ST_DATA;
                bit_cnt_q <= 5'd0;
                addr_q    <= rx_d[6:0];
                rw_q      <= rx_d[7];
                tx_q      <= rd_word(rx_d[6:0], regs_q);
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end
          ST_DATA: begin
            if (sample_s) begin
              rx_q <= rx_d[SH_W-2:0];
              if (bit_cnt_q == 5'(DATA_W - 1)) begin
                bit_cnt_q <= 5'd0;
                addr_q    <= addr_d;
                if (rw_q) begin
                  tx_q <= rd_word(addr_d, regs_q);
                end else if (in_range(addr_q)) begin
                  regs_q[addr_q[ADDR_W-1:0]] <= rx_d[DATA_W-1:0];
                  wr_stb_q                   <= 1'b1;
                  wr_addr_q                  <= addr_q[ADDR_W-1:0];
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end else if (shift_s && rw_q) begin
              miso_q <= tx_q[DATA_W-1];
              tx_q   <= tx_q << 1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            miso_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign spi_miso     = miso_q & ~sel_q[1];
  assign spi_miso_oeb = sel_q[1];
  assign reg_data     = regs_q;
  assign wr_stb       = wr_stb_q;
  assign wr_addr      = wr_addr_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_spi_regfile.sv
// Drives one spi_regfile per SPI mode with directed and random frames and compares
// against a register-array model of the command/burst/wrap rules.
module tb_spi_regfile;

  localparam int NREG = 4;
  localparam int H    = 80;

  logic        clk;
  logic        rst_n;
  logic [3:0]  sclk;
  logic [3:0]  sel;
  logic [3:0]  mosi;
  wire  [3:0]  miso;
  wire  [3:0]  oeb;
  wire  [3:0]  stb;
  wire  [3:0]  busy;
  wire  [1:0]  waddr [4];
  wire  [31:0] rdata [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_regfile #(
      .DATA_W (8),
      .NREG   (NREG),
      .CPOL   (g >= 2),
      .CPHA   (g % 2 == 1)
    ) u_dut (
      .wb_clk_i     (clk),
      .wb_rst_ni    (rst_n),
      .spi_clk      (sclk[g]),
      .spi_sel      (sel[g]),
      .spi_mosi     (mosi[g]),
      .spi_miso     (miso[g]),
      .spi_miso_oeb (oeb[g]),
      .reg_data     (rdata[g]),
      .wr_stb       (stb[g]),
      .wr_addr      (waddr[g]),
      .busy         (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cur_mode = 0;
  logic [7:0] model    [4][NREG];
  logic [7:0] tx_words [9];
  logic [7:0] rx_words [9];
  int         stb_log  [$];

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (stb[i]) stb_log.push_back(i * 16 + int'(waddr[i]));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s mode=%0d got=%0h exp=%0h", tag, cur_mode, obs, exp);
    end
  endtask

  // Master: MSB first, command byte, nw whole words, then extra partial bits.
  task automatic spi_frame(input int m, input logic [7:0] cmd, input int nw,
                           input int extra, input bit keep_sel);
    logic cpol, cpha, b, s;
    logic [7:0] rxb;
    int nbits;
    cpol  = (m >= 2);
    cpha  = (m % 2 == 1);
    nbits = 8 + 8 * nw + extra;
    rxb   = 8'h00;
    @(negedge clk);
    sel[m] = 1'b0;
    #(2 * H);
    for (int k = 0; k < nbits; k++) begin
      if (k < 8) b = cmd[7 - k];
      else       b = tx_words[(k - 8) / 8][7 - (k - 8) % 8];
      if (!cpha) begin
        mosi[m] = b;
        #(H);
        s = miso[m];
        sclk[m] = ~cpol;
        #(H);
        sclk[m] = cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi[m] = b;
        #(H);
        s = miso[m];
        sclk[m] = cpol;
        #(H);
      end
      if (k == 7) begin
        chk("busy_frame", {31'd0, busy[m]}, 32'd1);
        chk("oeb_frame", {31'd0, oeb[m]}, 32'd0);
      end
      if (k >= 8) begin
        rxb = {rxb[6:0], s};
        if ((k - 8) % 8 == 7) rx_words[(k - 8) / 8] = rxb;
      end
    end
    #(H);
    if (!keep_sel) begin
      sel[m]  = 1'b1;
      mosi[m] = 1'b0;
      #(8 * 10);
      chk("busy_idle", {31'd0, busy[m]}, 32'd0);
      chk("oeb_idle", {31'd0, oeb[m]}, 32'd1);
      chk("miso_idle", {31'd0, miso[m]}, 32'd0);
    end
  endtask

  task automatic run_frame(input int m, input logic [7:0] cmd, input int nw, input int extra);
    int a;
    logic [7:0] exp_rd [9];
    int exp_stb [$];
    cur_mode = m;
    a = int'(cmd[6:0]);
    for (int w = 0; w < nw; w++) begin
      if (cmd[7]) begin
        exp_rd[w] = (a < NREG) ? model[m][a] : 8'h00;
      end else begin
        exp_rd[w] = 8'h00;
        if (a < NREG) begin
          model[m][a] = tx_words[w];
          exp_stb.push_back(m * 16 + a);
        end
      end
      a = (a == NREG - 1) ? 0 : (a + 1) % 128;
    end
    stb_log.delete();
    spi_frame(m, cmd, nw, extra, 1'b0);
    chk("stb_count", 32'(stb_log.size()), 32'(exp_stb.size()));
    for (int i = 0; i < exp_stb.size() && i < stb_log.size(); i++)
      chk("stb_addr", 32'(stb_log[i]), 32'(exp_stb[i]));
    for (int w = 0; w < nw; w++)
      chk("miso_word", {24'd0, rx_words[w]}, {24'd0, exp_rd[w]});
    for (int r = 0; r < NREG; r++)
      chk("reg_val", {24'd0, rdata[m][r*8 +: 8]}, {24'd0, model[m][r]});
  endtask

  initial begin
    rst_n = 1'b0;
    sel   = 4'hF;
    sclk  = 4'b1100;
    mosi  = 4'h0;
    for (int i = 0; i < 4; i++)
      for (int r = 0; r < NREG; r++) model[i][r] = 8'h00;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      cur_mode = i;
      chk("rst_regs", rdata[i], 32'd0);
      chk("rst_oeb", {31'd0, oeb[i]}, 32'd1);
      chk("rst_busy", {31'd0, busy[i]}, 32'd0);
      chk("rst_miso", {31'd0, miso[i]}, 32'd0);
      chk("rst_waddr", {30'd0, waddr[i]}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_no_stb", 32'(stb_log.size()), 32'd0);

    for (int m = 0; m < 4; m++) begin
      tx_words[0] = 8'hA5;
      run_frame(m, 8'h01, 1, 0);
      tx_words[0] = 8'h11; tx_words[1] = 8'h22;
      run_frame(m, 8'h03, 2, 0);
      run_frame(m, 8'h81, 2, 0);
      tx_words[0] = 8'hFF;
      run_frame(m, 8'h02, 0, 4);
      tx_words[0] = 8'h5A;
      run_frame(m, 8'h02, 1, 0);
      tx_words[0] = 8'hFF;
      run_frame(m, 8'h05, 1, 0);
      run_frame(m, 8'h85, 1, 0);
    end

    for (int it = 0; it < 24; it++) begin
      int m, nw, extra;
      logic [7:0] cmd;
      m   = int'($urandom_range(0, 3));
      nw  = int'($urandom_range(1, 4));
      cmd = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 9))};
      extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      for (int w = 0; w < 9; w++) tx_words[w] = 8'($urandom());
      run_frame(m, cmd, nw, extra);
    end

    // Reset in the middle of a read frame on the mode-0 instance.
    cur_mode = 0;
    spi_frame(0, 8'h81, 0, 3, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      cur_mode = i;
      chk("midrst_regs", rdata[i], 32'd0);
      chk("midrst_miso", {31'd0, miso[i]}, 32'd0);
      chk("midrst_oeb", {31'd0, oeb[i]}, 32'd1);
      chk("midrst_busy", {31'd0, busy[i]}, 32'd0);
      chk("midrst_stb", {31'd0, stb[i]}, 32'd0);
      chk("midrst_waddr", {30'd0, waddr[i]}, 32'd0);
      for (int r = 0; r < NREG; r++) model[i][r] = 8'h00;
    end
    sel[0]  = 1'b1;
    sclk[0] = 1'b0;
    mosi[0] = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    run_frame(0, 8'h80, 4, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
